ccastles_vram_arb: RTL and testbench

CCASTLES_VRAM_ARB -- requirements
Module: ccastles_vram_arb

---
 rtl/ccastles_vram_arb.sv | 138 +++++++++++++
 tb/tb_ccastles_vram_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccastles_vram_arb.sv
// Video/CPU arbiter for a single-port bitmap RAM.
// Video fetches win by default; a CPU that has lost three video grants in a
// row while eligible is served next. Every grant drives the RAM address
// register. A two-stage tag pipeline then routes the RAM read data back to
// the owner of the access.
module ccastles_vram_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        vid_ovf,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   we;
  } tag_t;

  logic        vid_pend;
  logic [14:0] pend_addr;
  logic        cpu_busy;
  logic [1:0]  streak;
  tag_t        tag1;
  tag_t        tag2;

  logic        cpu_elig;
  logic        grant_vid;
  logic        grant_cpu;

  // Arbitration: at most one grant per edge, video first unless the CPU has been starved
  always_comb begin
    cpu_elig  = 1'b0;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    cpu_elig  = cpu_req && !cpu_busy && !cpu_ack;
    grant_vid = vid_pend && !((streak == 2'd3) && cpu_elig);
    grant_cpu = cpu_elig && !grant_vid;
  end

  // Video request capture. A request that arrives on the same edge the pending one
  // is granted refills the slot. A request that arrives while the slot stays occupied
  // is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_pend  <= 1'b0;
      pend_addr <= '0;
      vid_ovf   <= 1'b0;
    end else begin
      if (vid_req) begin
        if (vid_pend && !grant_vid) begin
          vid_ovf <= 1'b1;
        end else begin
          vid_pend  <= 1'b1;
          pend_addr <= vid_addr;
        end
      end else if (grant_vid) begin
        vid_pend <= 1'b0;
      end
    end
  end

  // Grant side: RAM port registers, starvation streak, CPU busy flag, first tag stage
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
      streak   <= '0;
      cpu_busy <= 1'b0;
      tag1     <= '0;
    end else begin
      ram_we <= 1'b0;
      if (grant_vid) begin
        ram_addr <= pend_addr;
      end else if (grant_cpu) begin
        ram_addr <= cpu_addr;
        ram_we   <= cpu_we;
        ram_din  <= cpu_din;
      end

      if (!cpu_elig || grant_cpu) begin
        streak <= '0;
      end else if (grant_vid && (streak != 2'd3)) begin
        streak <= streak + 2'd1;
      end

      if (grant_cpu) begin
        cpu_busy <= 1'b1;
      end else if (tag2.valid && (tag2.owner == OWN_CPU)) begin
        cpu_busy <= 1'b0;
      end

      tag1 <= '{valid: grant_vid || grant_cpu,
                owner: grant_cpu ? OWN_CPU : OWN_VID,
                we:    grant_cpu && cpu_we};
    end
  end

  // Completion side: second tag stage and return of RAM data to its owner
  always_ff @(posedge clk) begin
    if (reset) begin
      tag2      <= '0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_dout  <= '0;
    end else begin
      tag2      <= tag1;
      vid_valid <= tag2.valid && (tag2.owner == OWN_VID);
      cpu_ack   <= tag2.valid && (tag2.owner == OWN_CPU);
      if (tag2.valid && (tag2.owner == OWN_VID)) begin
        vid_data <= ram_dout;
      end
      if (tag2.valid && (tag2.owner == OWN_CPU) && !tag2.we) begin
        cpu_dout <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ccastles_vram_arb.sv
// Directed bench for ccastles_vram_arb. A RAM model returns a fixed address
// hash, or the last value written to that address. Expected read data is
// queued when a request is driven. The queued value is compared when
// vid_valid or cpu_ack fires.
module tb_ccastles_vram_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_ovf;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] vq[$];
  logic [8:0] cq[$];
  logic [8:0] exp_v;
  logic [8:0] exp_c;

  logic [7:0] wmem [int];
  logic [7:0] rd;

  bit  track = 1'b0;
  int  run_len = 0;
  int  max_run = 0;
  int  n_ack_phase = 0;
  bit  cpu_auto = 1'b0;
  int  cpu_seq = 0;

  always #5 clk = ~clk;

  ccastles_vram_arb dut (
    .clk      (clk),
    .reset    (reset),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_data (vid_data),
    .vid_valid(vid_valid),
    .vid_ovf  (vid_ovf),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_ack  (cpu_ack),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  function automatic logic [7:0] hash(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h7C;
  endfunction

  function automatic logic [8:0] mem_val(input logic [14:0] a);
    if (wmem.exists(int'(a))) return {1'b0, wmem[int'(a)]};
    return {1'b0, hash(a)};
  endfunction

  // Synchronous single-port RAM, read-before-write
  always @(posedge clk) begin
    rd = mem_val(ram_addr);
    if (ram_we) wmem[int'(ram_addr)] = ram_din;
    ram_dout <= rd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: each completion pulse pops the oldest expectation for its port
  always @(negedge clk) begin
    if (vid_valid) begin
      if (vq.size() > 0) exp_v = vq.pop_front();
      else exp_v = 9'h100;
      chk("vid_data", {23'd0, 1'b0, vid_data}, {23'd0, exp_v});
      if (track) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end
    end
    if (cpu_ack) begin
      if (cq.size() > 0) exp_c = cq.pop_front();
      else exp_c = 9'h100;
      chk("cpu_dout", {23'd0, 1'b0, cpu_dout}, {23'd0, exp_c});
      run_len = 0;
      if (track) n_ack_phase++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step while a free-running CPU reader issues the next read after each ack
  task automatic step_auto();
    step();
    if (cpu_auto && cpu_ack) begin
      cpu_seq++;
      cpu_addr = 15'h4000 + 15'(cpu_seq);
      cq.push_back(mem_val(cpu_addr));
    end
  endtask

  task automatic wait_cpu_ack(input int max, input string tag);
    int k;
    k = 0;
    while (!cpu_ack && k < max) begin
      step();
      k++;
    end
    chk(tag, {31'd0, cpu_ack}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    step();
    step();
    chk("rst_vid_valid", {31'd0, vid_valid}, 0);
    chk("rst_cpu_ack",   {31'd0, cpu_ack}, 0);
    chk("rst_ram_we",    {31'd0, ram_we}, 0);
    chk("rst_vid_ovf",   {31'd0, vid_ovf}, 0);
    chk("rst_ram_addr",  {17'd0, ram_addr}, 0);
    reset = 1'b0;
    step();

    // Lone video fetch: address at N+1, data at N+3
    vid_req = 1'b1; vid_addr = 15'h1234; vq.push_back(9'h05A);
    step();
    vid_req = 1'b0;
    chk("t1_valid_n0", {31'd0, vid_valid}, 0);
    step();
    chk("t1_ram_addr", {17'd0, ram_addr}, 32'h1234);
    chk("t1_ram_we",   {31'd0, ram_we}, 0);
    step();
    chk("t1_valid_n2", {31'd0, vid_valid}, 0);
    step();
    chk("t1_valid_n3", {31'd0, vid_valid}, 1);
    chk("t1_vid_data", {24'd0, vid_data}, 32'h5A);
    step();
    chk("t1_valid_pulse", {31'd0, vid_valid}, 0);

    // Lone CPU write: one-cycle ram_we, ack two edges after grant, dout untouched
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_din = 8'hC3;
    cq.push_back(9'h000);
    step();
    chk("t2_ram_we",   {31'd0, ram_we}, 1);
    chk("t2_ram_din",  {24'd0, ram_din}, 32'hC3);
    chk("t2_ram_addr", {17'd0, ram_addr}, 32'h0100);
    step();
    chk("t2_ram_we_off", {31'd0, ram_we}, 0);
    chk("t2_ack_g1",     {31'd0, cpu_ack}, 0);
    step();
    chk("t2_ack_g2", {31'd0, cpu_ack}, 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("t2_ack_single", {31'd0, cpu_ack}, 0);
    step();
    step();
    chk("t2_mem", {23'd0, mem_val(15'h0100)}, 32'hC3);

    // Video and CPU contending on the same arbitration edge: video first
    vid_req = 1'b1; vid_addr = 15'h2345; vq.push_back(mem_val(15'h2345));
    step();
    vid_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h4321; cpu_din = 8'h00;
    cq.push_back(mem_val(15'h4321));
    step();
    chk("t3_vid_first", {17'd0, ram_addr}, 32'h2345);
    step();
    chk("t3_cpu_next", {17'd0, ram_addr}, 32'h4321);
    chk("t3_cpu_rd_we", {31'd0, ram_we}, 0);
    wait_cpu_ack(8, "t3_cpu_ack");
    cpu_req = 1'b0;
    step();
    step();
    chk("t3_vq_empty", vq.size(), 0);

    // Video every two clocks against a continuously reading CPU
    cpu_seq = 0; cpu_we = 1'b0; cpu_addr = 15'h4000;
    cq.push_back(mem_val(15'h4000));
    cpu_req = 1'b1; cpu_auto = 1'b1;
    run_len = 0; max_run = 0; n_ack_phase = 0; track = 1'b1;
    for (int i = 0; i < 24; i++) begin
      vid_req = 1'b1; vid_addr = 15'h2000 + 15'(i * 5);
      vq.push_back(mem_val(vid_addr));
      step_auto();
      vid_req = 1'b0;
      step_auto();
    end
    cpu_auto = 1'b0;
    if (cpu_ack) step();
    wait_cpu_ack(10, "t4_drain_ack");
    cpu_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    track = 1'b0;
    chk("t4_ovf", {31'd0, vid_ovf}, 0);
    chk("t4_max_vid_run", {31'd0, max_run <= 3}, 1);
    chk("t4_cpu_share", {31'd0, n_ack_phase >= 8}, 1);
    chk("t4_vq_empty", vq.size(), 0);
    chk("t4_cq_empty", cq.size(), 0);

    // Streak of three video grants forces a CPU grant; back-to-back request is lost
    vid_req = 1'b1; vid_addr = 15'h2100; vq.push_back(mem_val(15'h2100));
    step();
    vid_addr = 15'h2101; vq.push_back(mem_val(15'h2101));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h4100;
    cq.push_back(mem_val(15'h4100));
    step();
    chk("t5_e1_addr", {17'd0, ram_addr}, 32'h2100);
    vid_addr = 15'h2102; vq.push_back(mem_val(15'h2102));
    step();
    chk("t5_e2_addr", {17'd0, ram_addr}, 32'h2101);
    vid_addr = 15'h2103; vq.push_back(mem_val(15'h2103));
    step();
    chk("t5_e3_addr", {17'd0, ram_addr}, 32'h2102);
    chk("t5_e3_ovf", {31'd0, vid_ovf}, 0);
    vid_addr = 15'h2104;
    step();
    chk("t5_cpu_forced", {17'd0, ram_addr}, 32'h4100);
    chk("t5_ovf_set", {31'd0, vid_ovf}, 1);
    vid_req = 1'b0;
    step();
    chk("t5_e5_addr", {17'd0, ram_addr}, 32'h2103);
    wait_cpu_ack(8, "t5_cpu_ack");
    cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t5_ovf_sticky", {31'd0, vid_ovf}, 1);
    chk("t5_vq_empty", vq.size(), 0);

    // Reset clears the sticky overflow
    reset = 1'b1;
    step();
    chk("t6_ovf_clr", {31'd0, vid_ovf}, 0);
    reset = 1'b0;
    step();

    // Reset one edge after a CPU read grant discards the access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h4200; cpu_din = 8'hA5;
    step();
    chk("t6_grant_addr", {17'd0, ram_addr}, 32'h4200);
    chk("t6_grant_din",  {24'd0, ram_din}, 32'hA5);
    reset = 1'b1; cpu_req = 1'b0; cpu_din = 8'h00;
    step();
    chk("t6_vid_data", {24'd0, vid_data}, 0);
    chk("t6_vid_valid", {31'd0, vid_valid}, 0);
    chk("t6_cpu_dout", {24'd0, cpu_dout}, 0);
    chk("t6_cpu_ack", {31'd0, cpu_ack}, 0);
    chk("t6_ram_addr", {17'd0, ram_addr}, 0);
    chk("t6_ram_we", {31'd0, ram_we}, 0);
    chk("t6_ram_din", {24'd0, ram_din}, 0);
    chk("t6_vid_ovf", {31'd0, vid_ovf}, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_stale_ack", {31'd0, cpu_ack}, 0);
    end
    cpu_req = 1'b1; cpu_addr = 15'h4201; cq.push_back(mem_val(15'h4201));
    step();
    chk("t6_next_addr", {17'd0, ram_addr}, 32'h4201);
    wait_cpu_ack(8, "t6_next_ack");
    cpu_req = 1'b0;
    vid_req = 1'b1; vid_addr = 15'h2200; vq.push_back(mem_val(15'h2200));
    step();
    vid_req = 1'b0;
    for (int i = 0; i < 5; i++) step();

    chk("end_vq_empty", vq.size(), 0);
    chk("end_cq_empty", cq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
